// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the multiplexed seven-segment driver: glyph data and
// masks from the game logic, board pin drive and status back.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] codes;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output codes, dp_in, blank_mask, blink_mask, load,
    input  seg, dp, an, frame_tick, pending
  );

  modport slave (
    input  codes, dp_in, blank_mask, blink_mask, load,
    output seg, dp, an, frame_tick, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with dead time, blink/blank masks and
// frame-synchronous double-buffered display data.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 7'h40;
      5'd1:    glyph = 7'h79;
      5'd2:    glyph = 7'h24;
      5'd3:    glyph = 7'h30;
      5'd4:    glyph = 7'h19;
      5'd5:    glyph = 7'h12;
      5'd6:    glyph = 7'h02;
      5'd7:    glyph = 7'h78;
      5'd8:    glyph = 7'h00;
      5'd9:    glyph = 7'h10;
      5'd10:   glyph = 7'h08;
      5'd11:   glyph = 7'h03;
      5'd12:   glyph = 7'h46;
      5'd13:   glyph = 7'h21;
      5'd14:   glyph = 7'h06;
      5'd15:   glyph = 7'h0E;
      5'd16:   glyph = 7'h2F;
      default: glyph = 7'h7F;
    endcase
  endfunction

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [5*NUM_DIGITS-1:0] stage_codes, disp_codes;
  logic [NUM_DIGITS-1:0]   stage_dp, stage_blank, stage_blink;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, disp_blink;
  logic                    pending;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    tick_r;

  logic                    presc_last, idx_last, boundary, xfer, vis, lit;
  logic [PW-1:0]           presc_nx;
  logic [IW-1:0]           idx_nx;
  logic [FW-1:0]           frame_nx;
  logic                    phase_nx;
  logic [5*NUM_DIGITS-1:0] codes_nx;
  logic [NUM_DIGITS-1:0]   dp_mask_nx, blank_nx, blink_nx, an_nx;
  logic [4:0]              code_cur;
  int                      cur;

  // Outputs are derived from next-state values so the registered pins always
  // match the prescaler/index registers they are clocked alongside.
  always_comb begin
    presc_last = (presc == PW'(SCAN_DIV - 1));
    idx_last   = (idx == IW'(NUM_DIGITS - 1));
    boundary   = presc_last && idx_last;
    xfer       = boundary && pending;
    presc_nx   = presc_last ? '0 : presc + PW'(1);
    idx_nx     = idx;
    if (presc_last) idx_nx = idx_last ? '0 : idx + IW'(1);

    frame_nx = frame_cnt;
    phase_nx = blink_phase;
    if (boundary) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_nx = '0;
        phase_nx = ~blink_phase;
      end else begin
        frame_nx = frame_cnt + FW'(1);
      end
    end

    codes_nx   = xfer ? stage_codes : disp_codes;
    dp_mask_nx = xfer ? stage_dp    : disp_dp;
    blank_nx   = xfer ? stage_blank : disp_blank;
    blink_nx   = xfer ? stage_blink : disp_blink;

    cur      = int'(idx_nx);
    code_cur = codes_nx[5*cur +: 5];
    vis      = !blank_nx[cur] && !(blink_nx[cur] && phase_nx);
    lit      = vis && (int'(presc_nx) >= DEAD_CYCLES);
    an_nx    = '1;
    if (lit) an_nx[cur] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      stage_codes <= '1;
      disp_codes  <= '1;
      stage_dp    <= '0;
      stage_blank <= '0;
      stage_blink <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      disp_blink  <= '0;
      pending     <= 1'b0;
      seg_r       <= 7'h7F;
      dp_r        <= 1'b1;
      an_r        <= '1;
      tick_r      <= 1'b0;
    end else begin
      presc       <= presc_nx;
      idx         <= idx_nx;
      frame_cnt   <= frame_nx;
      blink_phase <= phase_nx;
      disp_codes  <= codes_nx;
      disp_dp     <= dp_mask_nx;
      disp_blank  <= blank_nx;
      disp_blink  <= blink_nx;
      // A load on a boundary edge keeps pending set for the following frame.
      if (bus.load) begin
        stage_codes <= bus.codes;
        stage_dp    <= bus.dp_in;
        stage_blank <= bus.blank_mask;
        stage_blink <= bus.blink_mask;
        pending     <= 1'b1;
      end else if (xfer) begin
        pending     <= 1'b0;
      end
      seg_r  <= vis ? glyph(code_cur) : 7'h7F;
      dp_r   <= vis ? ~dp_mask_nx[cur] : 1'b1;
      an_r   <= an_nx;
      tick_r <= boundary;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.an         = an_r;
  assign bus.frame_tick = tick_r;
  assign bus.pending    = pending;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2 dead cycles,
// 2-frame blink half-period.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus();

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [4:0] code;
    logic [6:0] seg;
  } vec_t;

  vec_t       sweep[32];
  logic [6:0] gtab[32];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_tick();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = bus.frame_tick;
    end
    chk("frame_tick_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic do_load(input logic [19:0] c, input logic [3:0] d,
                         input logic [3:0] bl, input logic [3:0] bk);
    bus.codes      = c;
    bus.dp_in      = d;
    bus.blank_mask = bl;
    bus.blink_mask = bk;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic [3:0] one;
    logic [6:0] t1_seg[4];
    bit         vis_pat[6];
    int         bad;

    gtab[0] = 7'h40; gtab[1] = 7'h79; gtab[2] = 7'h24; gtab[3] = 7'h30;
    gtab[4] = 7'h19; gtab[5] = 7'h12; gtab[6] = 7'h02; gtab[7] = 7'h78;
    gtab[8] = 7'h00; gtab[9] = 7'h10; gtab[10] = 7'h08; gtab[11] = 7'h03;
    gtab[12] = 7'h46; gtab[13] = 7'h21; gtab[14] = 7'h06; gtab[15] = 7'h0E;
    gtab[16] = 7'h2F;
    for (int i = 17; i < 32; i++) gtab[i] = 7'h7F;
    for (int i = 0; i < 32; i++) begin
      sweep[i].code = 5'(i);
      sweep[i].seg  = gtab[i];
    end
    t1_seg[0] = 7'h40; t1_seg[1] = 7'h79; t1_seg[2] = 7'h24; t1_seg[3] = 7'h30;
    vis_pat[0] = 1; vis_pat[1] = 0; vis_pat[2] = 0;
    vis_pat[3] = 1; vis_pat[4] = 1; vis_pat[5] = 0;
    one = 4'b0001;

    bus.codes = '1; bus.dp_in = '0; bus.blank_mask = '0; bus.blink_mask = '0;
    bus.load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    rst_n = 1'b1;

    // Basic scan of {3,2,1,0}
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'h0, 4'h0, 4'h0);
    chk("t1_pending_set", 32'(bus.pending), 32'h1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.seg !== 7'h7F || bus.pending !== 1'b1 || bus.frame_tick !== 1'b0) bad++;
    end
    chk("t1_frame0_blank", 32'(bad), 32'd0);
    wait_tick();
    chk("t1_pending_clr", 32'(bus.pending), 32'h0);
    for (int i = 0; i < 32; i++) begin
      exp_an  = (i % SD < DC) ? 4'hF : ~(one << (i / SD));
      exp_seg = t1_seg[i / SD];
      chk($sformatf("t1_an_c%0d", i), 32'(bus.an), 32'(exp_an));
      chk($sformatf("t1_seg_c%0d", i), 32'(bus.seg), 32'(exp_seg));
      chk($sformatf("t1_dp_c%0d", i), 32'(bus.dp), 32'h1);
      @(negedge clk);
    end

    // Code sweep on digit 0
    for (int v = 0; v < 32; v++) begin
      do_load({15'h7FFF, sweep[v].code}, 4'h0, 4'h0, 4'h0);
      wait_tick();
      repeat (2) @(negedge clk);
      chk($sformatf("sweep_seg_%0d", v), 32'(bus.seg), 32'(sweep[v].seg));
      chk($sformatf("sweep_an_%0d", v), 32'(bus.an), 32'hE);
    end

    // Double load within a frame: last one wins
    do_load({15'h7FFF, 5'd5}, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    do_load({15'h7FFF, 5'd6}, 4'h0, 4'h0, 4'h0);
    wait_tick();
    repeat (2) @(negedge clk);
    chk("dbl_seg", 32'(bus.seg), 32'h02);

    // Load on the boundary edge while staging is pending
    do_load({15'h7FFF, 5'd8}, 4'h0, 4'h0, 4'h0);
    repeat (28) @(negedge clk);
    do_load({15'h7FFF, 5'd7}, 4'h0, 4'h0, 4'h0);
    chk("coinc_tick", 32'(bus.frame_tick), 32'h1);
    chk("coinc_pending", 32'(bus.pending), 32'h1);
    repeat (2) @(negedge clk);
    chk("coinc_seg_old", 32'(bus.seg), 32'h00);
    wait_tick();
    repeat (2) @(negedge clk);
    chk("coinc_seg_new", 32'(bus.seg), 32'h78);
    chk("coinc_pending_clr", 32'(bus.pending), 32'h0);

    // Blink on digit 0, decimal point on digit 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load({5'd8, 5'd8, 5'd8, 5'd8}, 4'b0010, 4'b0000, 4'b0001);
    for (int f = 0; f < 6; f++) begin
      wait_tick();
      repeat (2) @(negedge clk);
      chk($sformatf("blink_an_f%0d", f), 32'(bus.an), vis_pat[f] ? 32'hE : 32'hF);
      chk($sformatf("blink_seg_f%0d", f), 32'(bus.seg), vis_pat[f] ? 32'h00 : 32'h7F);
      chk($sformatf("blink_dp0_f%0d", f), 32'(bus.dp), 32'h1);
      repeat (8) @(negedge clk);
      chk($sformatf("dp1_an_f%0d", f), 32'(bus.an), 32'hD);
      chk($sformatf("dp1_dp_f%0d", f), 32'(bus.dp), 32'h0);
      repeat (8) @(negedge clk);
      chk($sformatf("dp2_dp_f%0d", f), 32'(bus.dp), 32'h1);
    end

    // All digits blanked: dark pins, ticks continue
    do_load(20'h0, 4'h0, 4'hF, 4'h0);
    wait_tick();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("blank_an_%0d", i), 32'(bus.an), 32'hF);
      chk($sformatf("blank_seg_%0d", i), 32'(bus.seg), 32'h7F);
      chk($sformatf("blank_tick_%0d", i), 32'(bus.frame_tick), (i % 32 == 0) ? 32'h1 : 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of slot 2
    do_load(20'h0, 4'h0, 4'h0, 4'h0);
    wait_tick();
    repeat (21) @(negedge clk);
    chk("mid_an_pre", 32'(bus.an), 32'hB);
    chk("mid_seg_pre", 32'(bus.seg), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_dp", 32'(bus.dp), 32'h1);
    chk("arst_an", 32'(bus.an), 32'hF);
    chk("arst_pending", 32'(bus.pending), 32'h0);
    chk("arst_tick", 32'(bus.frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_an_c1", 32'(bus.an), 32'hF);
    chk("rel_tick_c1", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    chk("rel_an_c2", 32'(bus.an), 32'hE);
    chk("rel_seg_c2", 32'(bus.seg), 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
